spc_stack_ctl: RTL and testbench

//  Stack controller (initiator side) for the 32x19 synchronous SPC stack RAM.

---
 rtl/spc_stack_if.sv | 35 +++
 rtl/spc_stack_ctl.sv | 173 +++++++++++++++++
 tb/tb_spc_stack_ctl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spc_stack_if.sv
// Sequencer/RAM-facing bundle of the SPC stack controller.
// slave = controller view; master = sequencer plus RAM instance view.
interface spc_stack_if #(
    parameter int AW = 5,
    parameter int DW = 19
);
    logic          PUSH;
    logic          POP;
    logic [DW-1:0] PUSH_DATA;
    logic          BUSY;
    logic [DW-1:0] POP_DATA;
    logic          POP_VALID;
    logic [AW-1:0] SPTR;
    logic          EMPTY;
    logic          FULL;
    logic          OVF;
    logic          UNF;
    logic [AW-1:0] RAM_A;
    logic [DW-1:0] RAM_DI;
    logic          RAM_WE_N;
    logic          RAM_CE_N;
    logic [DW-1:0] RAM_DO;

    modport master (
        output PUSH, POP, PUSH_DATA, RAM_DO,
        input  BUSY, POP_DATA, POP_VALID, SPTR, EMPTY, FULL, OVF, UNF,
               RAM_A, RAM_DI, RAM_WE_N, RAM_CE_N
    );

    modport slave (
        input  PUSH, POP, PUSH_DATA, RAM_DO,
        output BUSY, POP_DATA, POP_VALID, SPTR, EMPTY, FULL, OVF, UNF,
               RAM_A, RAM_DI, RAM_WE_N, RAM_CE_N
    );
endinterface

// File: rtl/spc_stack_ctl.sv
// SPC stack controller: push/pop/replace against a 32x19 synchronous RAM.
// Optional macro SPC_BOUNDS_EN rejects push-when-full and pop-when-empty.
//
// state  | meaning
// IDLE   | accepting requests, RAM strobes idle
// WR     | push write strobed to RAM this edge
// RD     | read strobed to RAM this edge
// CAP    | RAM_DO valid; capture popped word
// RPL_WR | replace write strobed to RAM this edge
module spc_stack_ctl #(
    parameter int AW = 5,
    parameter int DW = 19
) (
    input  logic       CLK,
    input  logic       RESET,
    spc_stack_if.slave bus
);
    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, WR, RD, CAP, RPL_WR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] sptr, sptr_nxt;
    logic [AW:0]   count, count_nxt;
    logic          ovf, ovf_nxt;
    logic          unf, unf_nxt;
    logic          rpl, rpl_nxt;
    logic [DW-1:0] pop_data, pop_data_nxt;
    logic          pop_valid, pop_valid_nxt;
    logic [AW-1:0] ram_a, ram_a_nxt;
    logic [DW-1:0] ram_di, ram_di_nxt;
    logic          ram_we_n, ram_we_n_nxt;
    logic          ram_ce_n, ram_ce_n_nxt;

    logic empty, full, push_ok, pop_ok;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

`ifdef SPC_BOUNDS_EN
    assign push_ok = !full;
    assign pop_ok  = !empty;
`else
    assign push_ok = 1'b1;
    assign pop_ok  = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sptr      <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            rpl       <= 1'b0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            ram_a     <= '0;
            ram_di    <= '0;
            ram_we_n  <= 1'b1;
            ram_ce_n  <= 1'b1;
        end else begin
            sptr      <= sptr_nxt;
            count     <= count_nxt;
            ovf       <= ovf_nxt;
            unf       <= unf_nxt;
            rpl       <= rpl_nxt;
            pop_data  <= pop_data_nxt;
            pop_valid <= pop_valid_nxt;
            ram_a     <= ram_a_nxt;
            ram_di    <= ram_di_nxt;
            ram_we_n  <= ram_we_n_nxt;
            ram_ce_n  <= ram_ce_n_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sptr_nxt      = sptr;
        count_nxt     = count;
        ovf_nxt       = ovf;
        unf_nxt       = unf;
        rpl_nxt       = rpl;
        pop_data_nxt  = pop_data;
        pop_valid_nxt = 1'b0;
        ram_a_nxt     = ram_a;
        ram_di_nxt    = ram_di;
        ram_we_n_nxt  = ram_we_n;
        ram_ce_n_nxt  = ram_ce_n;

        case (state)
            IDLE: begin
                if (bus.PUSH && !bus.POP) begin
                    if (full) ovf_nxt = 1'b1;
                    if (push_ok) begin
                        sptr_nxt     = sptr + 1'b1;
                        ram_a_nxt    = sptr + 1'b1;
                        ram_di_nxt   = bus.PUSH_DATA;
                        ram_ce_n_nxt = 1'b0;
                        ram_we_n_nxt = 1'b0;
                        count_nxt    = full ? count : count + 1'b1;
                        state_nxt    = WR;
                    end
                end else if (bus.POP) begin
                    if (empty) unf_nxt = 1'b1;
                    if (pop_ok) begin
                        ram_a_nxt    = sptr;
                        ram_ce_n_nxt = 1'b0;
                        ram_we_n_nxt = 1'b1;
                        rpl_nxt      = bus.PUSH;
                        state_nxt    = RD;
                        // Replace keeps pointer and count; the new word waits in RAM_DI.
                        if (bus.PUSH) begin
                            ram_di_nxt = bus.PUSH_DATA;
                        end else begin
                            sptr_nxt  = sptr - 1'b1;
                            count_nxt = empty ? count : count - 1'b1;
                        end
                    end
                end
            end
            WR: begin
                ram_ce_n_nxt = 1'b1;
                ram_we_n_nxt = 1'b1;
                state_nxt    = IDLE;
            end
            RD: begin
                ram_ce_n_nxt = 1'b1;
                state_nxt    = CAP;
            end
            CAP: begin
                pop_data_nxt  = bus.RAM_DO;
                pop_valid_nxt = 1'b1;
                if (rpl) begin
                    ram_a_nxt    = sptr;
                    ram_ce_n_nxt = 1'b0;
                    ram_we_n_nxt = 1'b0;
                    state_nxt    = RPL_WR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RPL_WR: begin
                ram_ce_n_nxt = 1'b1;
                ram_we_n_nxt = 1'b1;
                rpl_nxt      = 1'b0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.BUSY      = (state != IDLE);
    assign bus.POP_DATA  = pop_data;
    assign bus.POP_VALID = pop_valid;
    assign bus.SPTR      = sptr;
    assign bus.EMPTY     = empty;
    assign bus.FULL      = full;
    assign bus.OVF       = ovf;
    assign bus.UNF       = unf;
    assign bus.RAM_A     = ram_a;
    assign bus.RAM_DI    = ram_di;
    assign bus.RAM_WE_N  = ram_we_n;
    assign bus.RAM_CE_N  = ram_ce_n;
endmodule

// File: tb/tb_spc_stack_ctl.sv
// Bench for spc_stack_ctl with a behavioural 32x19 synchronous RAM.
module tb_spc_stack_ctl;
    localparam int AW = 5;
    localparam int DW = 19;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    spc_stack_if #(.AW(AW), .DW(DW)) bus ();
    spc_stack_ctl #(.AW(AW), .DW(DW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    logic [DW-1:0] mem [32] = '{default: '0};
    int wr_cnt = 0;
    int ce_cnt = 0;

    always @(posedge CLK) begin
        if (!bus.RAM_CE_N) begin
            ce_cnt <= ce_cnt + 1;
            if (!bus.RAM_WE_N) begin
                mem[bus.RAM_A] <= bus.RAM_DI;
                wr_cnt <= wr_cnt + 1;
            end else begin
                bus.RAM_DO <= mem[bus.RAM_A];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic do_op(input logic p, input logic q, input logic [DW-1:0] d, input logic exp_valid,
                         output logic got, output logic [DW-1:0] pd, output int lat,
                         output logic [AW-1:0] a_iss);
        int  cyc;
        logic done;
        @(negedge CLK);
        bus.PUSH = p;
        bus.POP = q;
        bus.PUSH_DATA = d;
        @(posedge CLK);
        #1;
        bus.PUSH = 1'b0;
        bus.POP = 1'b0;
        a_iss = bus.RAM_A;
        got = 1'b0;
        pd = '0;
        lat = -1;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 8) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (bus.POP_VALID) begin
                got = 1'b1;
                pd = bus.POP_DATA;
                lat = cyc;
            end
            if (!bus.BUSY && (got || !exp_valid)) done = 1'b1;
        end
        chk("op_completes", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic          push;
        logic          pop;
        logic [DW-1:0] data;
        logic          exp_valid;
        logic [DW-1:0] exp_pd;
        logic [AW-1:0] exp_a;
        logic [AW-1:0] exp_sptr;
        logic          exp_empty;
        logic          chk_mem;
        logic [DW-1:0] mem_val;
    } vec_t;

    vec_t tbl [7];

    logic          got;
    logic [DW-1:0] pd;
    int            lat;
    logic [AW-1:0] a_iss;
    int            wb, cb;
    logic          seen;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            push  pop   data      valid pop_data  a     sptr  empty chkmem memval
        tbl[0] = '{1'b1, 1'b0, 19'o1234, 1'b0, 19'o0,    5'd1, 5'd1, 1'b0, 1'b1, 19'o1234};
        tbl[1] = '{1'b1, 1'b0, 19'o5670, 1'b0, 19'o0,    5'd2, 5'd2, 1'b0, 1'b1, 19'o5670};
        tbl[2] = '{1'b0, 1'b1, 19'o0,    1'b1, 19'o5670, 5'd2, 5'd1, 1'b0, 1'b0, 19'o0};
        tbl[3] = '{1'b0, 1'b1, 19'o0,    1'b1, 19'o1234, 5'd1, 5'd0, 1'b1, 1'b0, 19'o0};
        tbl[4] = '{1'b1, 1'b0, 19'o7,    1'b0, 19'o0,    5'd1, 5'd1, 1'b0, 1'b1, 19'o7};
        tbl[5] = '{1'b1, 1'b1, 19'o3,    1'b1, 19'o7,    5'd1, 5'd1, 1'b0, 1'b1, 19'o3};
        tbl[6] = '{1'b0, 1'b1, 19'o0,    1'b1, 19'o3,    5'd1, 5'd0, 1'b1, 1'b0, 19'o0};

        bus.PUSH = 1'b0;
        bus.POP = 1'b0;
        bus.PUSH_DATA = '0;
        do_reset();

        chk("reset_sptr", 32'(bus.SPTR), 32'd0);
        chk("reset_empty", 32'(bus.EMPTY), 32'd1);
        chk("reset_full", 32'(bus.FULL), 32'd0);
        chk("reset_ce_n", 32'(bus.RAM_CE_N), 32'd1);
        chk("reset_we_n", 32'(bus.RAM_WE_N), 32'd1);
        chk("reset_busy", 32'(bus.BUSY), 32'd0);
        chk("reset_pop_valid", 32'(bus.POP_VALID), 32'd0);
        chk("reset_ovf", 32'(bus.OVF), 32'd0);
        chk("reset_unf", 32'(bus.UNF), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].push, tbl[i].pop, tbl[i].data, tbl[i].exp_valid, got, pd, lat, a_iss);
            chk($sformatf("vec%0d_valid", i), 32'(got), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("vec%0d_pop_data", i), 32'(pd), 32'(tbl[i].exp_pd));
                chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            end
            chk($sformatf("vec%0d_ram_a", i), 32'(a_iss), 32'(tbl[i].exp_a));
            chk($sformatf("vec%0d_sptr", i), 32'(bus.SPTR), 32'(tbl[i].exp_sptr));
            chk($sformatf("vec%0d_empty", i), 32'(bus.EMPTY), 32'(tbl[i].exp_empty));
            if (tbl[i].chk_mem)
                chk($sformatf("vec%0d_mem", i), 32'(mem[tbl[i].exp_a]), 32'(tbl[i].mem_val));
        end
        chk("after_vec_unf", 32'(bus.UNF), 32'd0);

        // pop from empty
        cb = ce_cnt;
`ifdef SPC_BOUNDS_EN
        do_op(1'b0, 1'b1, '0, 1'b0, got, pd, lat, a_iss);
        chk("unf_pop_valid", 32'(got), 32'd0);
        chk("unf_sptr", 32'(bus.SPTR), 32'd0);
        chk("unf_ce_pulses", 32'(ce_cnt - cb), 32'd0);
`else
        do_op(1'b0, 1'b1, '0, 1'b1, got, pd, lat, a_iss);
        chk("unf_pop_valid", 32'(got), 32'd1);
        chk("unf_ram_a", 32'(a_iss), 32'd0);
        chk("unf_sptr", 32'(bus.SPTR), 32'd31);
        chk("unf_ce_pulses", 32'(ce_cnt - cb), 32'd1);
`endif
        chk("unf_flag", 32'(bus.UNF), 32'd1);
        chk("unf_empty", 32'(bus.EMPTY), 32'd1);

        // fill to full, then overflow
        do_reset();
        chk("reset_clears_unf", 32'(bus.UNF), 32'd0);
        for (int i = 1; i <= 32; i++)
            do_op(1'b1, 1'b0, 19'(i), 1'b0, got, pd, lat, a_iss);
        chk("fill_full", 32'(bus.FULL), 32'd1);
        chk("fill_sptr", 32'(bus.SPTR), 32'd0);
        chk("fill_ovf", 32'(bus.OVF), 32'd0);
        chk("fill_mem0", 32'(mem[0]), 32'd32);
        wb = wr_cnt;
        do_op(1'b1, 1'b0, 19'o777, 1'b0, got, pd, lat, a_iss);
        chk("ovf_flag", 32'(bus.OVF), 32'd1);
        chk("ovf_full", 32'(bus.FULL), 32'd1);
`ifdef SPC_BOUNDS_EN
        chk("ovf_sptr", 32'(bus.SPTR), 32'd0);
        chk("ovf_writes", 32'(wr_cnt - wb), 32'd0);
        chk("ovf_mem1", 32'(mem[1]), 32'd1);
`else
        chk("ovf_sptr", 32'(bus.SPTR), 32'd1);
        chk("ovf_writes", 32'(wr_cnt - wb), 32'd1);
        chk("ovf_mem1", 32'(mem[1]), 32'o777);
`endif

        // push while busy is ignored
        do_reset();
        chk("reset_clears_ovf", 32'(bus.OVF), 32'd0);
        wb = wr_cnt;
        @(negedge CLK);
        bus.PUSH = 1'b1;
        bus.PUSH_DATA = 19'o11;
        @(posedge CLK);
        #1;
        bus.PUSH_DATA = 19'o22;
        chk("busy_during_push", 32'(bus.BUSY), 32'd1);
        @(posedge CLK);
        #1;
        bus.PUSH = 1'b0;
        @(posedge CLK);
        #1;
        chk("busy_push_sptr", 32'(bus.SPTR), 32'd1);
        chk("busy_push_writes", 32'(wr_cnt - wb), 32'd1);
        chk("busy_push_mem1", 32'(mem[1]), 32'o11);
        chk("busy_push_mem2", 32'(mem[2]), 32'd2);
        do_op(1'b0, 1'b1, '0, 1'b1, got, pd, lat, a_iss);
        chk("busy_pop_data", 32'(pd), 32'o11);
        chk("busy_pop_empty", 32'(bus.EMPTY), 32'd1);

        // reset while a pop is in flight
        do_op(1'b1, 1'b0, 19'o55, 1'b0, got, pd, lat, a_iss);
        chk("pre_abort_sptr", 32'(bus.SPTR), 32'd1);
        @(negedge CLK);
        bus.POP = 1'b1;
        @(posedge CLK);
        #1;
        bus.POP = 1'b0;
        chk("abort_ce_active", 32'(bus.RAM_CE_N), 32'd0);
        RESET = 1'b1;
        #1;
        chk("abort_ce_n", 32'(bus.RAM_CE_N), 32'd1);
        chk("abort_sptr", 32'(bus.SPTR), 32'd0);
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge CLK);
            #1;
            if (bus.POP_VALID) seen = 1'b1;
        end
        chk("abort_no_pop_valid", 32'(seen), 32'd0);
        chk("abort_empty", 32'(bus.EMPTY), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
